// File: rtl/fuzz_stim_misr_harness.sv
// Stimulus/response harness: drives a zero vector then NUM_VEC vectors (internal LFSR or external
// ready/valid source) into a DUT input bus and folds the DUT response into a MISR signature.
module fuzz_stim_misr_harness #(
    parameter int          IN_W      = 49,
    parameter int          OUT_W     = 350,
    parameter int          SIG_W     = 32,
    parameter int          NUM_VEC   = 21,
    parameter int          HOLD_CYC  = 1,
    parameter logic [31:0] SEED      = 32'h00000001,
    parameter logic [31:0] LFSR_POLY = 32'h80200003,
    parameter logic [31:0] MISR_POLY = 32'h04C11DB7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [IN_W-1:0]  ext_vec,
    input  logic             ext_valid,
    output logic             ext_ready,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig,
    output logic [15:0]      vec_cnt
);

    localparam int               HC_W      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYC - 1);
    localparam logic [15:0]      VEC_LAST  = 16'(NUM_VEC);
    localparam int               NCH       = (OUT_W + SIG_W - 1) / SIG_W;
    localparam logic [31:0]      SEED_EFF  = (SEED == 32'h00000000) ? 32'h00000001 : SEED;
    localparam logic [SIG_W-1:0] MISR_TAPS = SIG_W'(MISR_POLY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // XOR of the response cut into SIG_W-bit chunks from the LSB, last chunk zero-padded.
    function automatic logic [SIG_W-1:0] fold(input logic [OUT_W-1:0] r);
        logic [NCH*SIG_W-1:0] pad;
        logic [SIG_W-1:0]     acc;
        pad            = '0;
        pad[OUT_W-1:0] = r;
        acc            = '0;
        for (int i = 0; i < NCH; i++) begin
            acc = acc ^ pad[i*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                    input logic [OUT_W-1:0] r);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_TAPS : {SIG_W{1'b0}}) ^ fold(r);
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? LFSR_POLY : 32'h00000000);
    endfunction

    // The 32-bit LFSR word repeats upward from bit 0; excess bits are dropped at the MSB.
    function automatic logic [IN_W-1:0] replicate(input logic [31:0] l);
        logic [IN_W-1:0] r;
        for (int i = 0; i < IN_W; i++) begin
            r[i] = l[i % 32];
        end
        return r;
    endfunction

    state_t           state_r;
    logic             mode_r;
    logic [31:0]      lfsr_r;
    logic [HC_W-1:0]  hold_cnt_r;
    logic [IN_W-1:0]  stim_r;
    logic [SIG_W-1:0] sig_r;
    logic [15:0]      vec_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             ext_ready_r;

    logic [SIG_W-1:0] misr_nxt_s;
    logic             last_hold_s;
    logic             last_vec_s;

    // Next-signature and end-of-hold / end-of-run decodes.
    always_comb begin
        misr_nxt_s  = misr_next(sig_r, resp);
        last_hold_s = (hold_cnt_r == HOLD_LAST);
        last_vec_s  = (vec_cnt_r == VEC_LAST);
    end

    // Run control FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            mode_r      <= 1'b0;
            lfsr_r      <= SEED_EFF;
            hold_cnt_r  <= {HC_W{1'b0}};
            stim_r      <= {IN_W{1'b0}};
            sig_r       <= {SIG_W{1'b0}};
            vec_cnt_r   <= 16'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ext_ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r     <= HOLD;
                        mode_r      <= mode;
                        lfsr_r      <= SEED_EFF;
                        hold_cnt_r  <= {HC_W{1'b0}};
                        stim_r      <= {IN_W{1'b0}};
                        sig_r       <= {SIG_W{1'b0}};
                        vec_cnt_r   <= 16'd0;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        ext_ready_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                HOLD: begin
                    if (last_hold_s) begin
                        // One MISR capture per vector, on the edge that ends its hold window.
                        sig_r      <= misr_nxt_s;
                        hold_cnt_r <= {HC_W{1'b0}};
                        if (last_vec_s) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else if (!mode_r) begin
                            stim_r    <= replicate(lfsr_r);
                            lfsr_r    <= lfsr_next(lfsr_r);
                            vec_cnt_r <= vec_cnt_r + 16'd1;
                        end else begin
                            state_r     <= FETCH;
                            ext_ready_r <= 1'b1;
                        end
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HC_W'(1);
                    end
                end
                FETCH: begin
                    if (ext_valid && ext_ready_r) begin
                        stim_r      <= ext_vec;
                        vec_cnt_r   <= vec_cnt_r + 16'd1;
                        ext_ready_r <= 1'b0;
                        hold_cnt_r  <= {HC_W{1'b0}};
                        state_r     <= HOLD;
                    end else begin
                        ext_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    ext_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign stim      = stim_r;
    assign sig       = sig_r;
    assign vec_cnt   = vec_cnt_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign ext_ready = ext_ready_r;

endmodule

// File: tb/tb_fuzz_stim_misr_harness.sv
// Scoreboard bench: stimulus pushes expected per-busy-cycle and end-of-run records; monitors pop
// and compare whenever a harness instance shows busy or a rising done.
module tb_fuzz_stim_misr_harness;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2, mode, ext_valid, loop1;
    logic [31:0] ext_vec;

    logic        ext_ready1, busy1, done1;
    logic [31:0] stim1, sig1, resp1;
    logic [15:0] cnt1;

    logic        ext_ready2, busy2, done2;
    logic [39:0] stim2, resp2;
    logic [31:0] sig2;
    logic [15:0] cnt2;

    assign resp1 = loop1 ? stim1 : 32'h00000000;
    assign resp2 = stim2;

    always #5 clk = ~clk;

    fuzz_stim_misr_harness #(
        .IN_W(32), .OUT_W(32), .SIG_W(32), .NUM_VEC(2), .HOLD_CYC(1),
        .SEED(32'h00000001), .LFSR_POLY(32'h80200003), .MISR_POLY(32'h04C11DB7)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode),
        .ext_vec(ext_vec), .ext_valid(ext_valid), .ext_ready(ext_ready1),
        .stim(stim1), .resp(resp1), .busy(busy1), .done(done1),
        .sig(sig1), .vec_cnt(cnt1)
    );

    // 40-bit buses exercise replication truncation and a zero-padded second fold chunk.
    fuzz_stim_misr_harness #(
        .IN_W(40), .OUT_W(40), .SIG_W(32), .NUM_VEC(2), .HOLD_CYC(3),
        .SEED(32'h00000001), .LFSR_POLY(32'h80200003), .MISR_POLY(32'h04C11DB7)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode),
        .ext_vec(40'h0000000000), .ext_valid(1'b0), .ext_ready(ext_ready2),
        .stim(stim2), .resp(resp2), .busy(busy2), .done(done2),
        .sig(sig2), .vec_cnt(cnt2)
    );

    typedef struct packed {
        logic [39:0] stim;
        logic [31:0] sig;
        logic [15:0] cnt;
        logic        rdy;
        logic        dn;
    } rec_t;

    rec_t bq1[$];
    rec_t dq1[$];
    rec_t bq2[$];
    rec_t dq2[$];
    int   checks   = 0;
    int   failures = 0;
    logic done1_q  = 1'b0;
    logic done2_q  = 1'b0;

    function automatic rec_t mk(input logic [39:0] s, input logic [31:0] g,
                                input logic [15:0] c, input logic r, input logic d);
        return {s, g, c, r, d};
    endfunction

    function automatic rec_t cur1();
        return {8'h00, stim1, sig1, cnt1, ext_ready1, done1};
    endfunction

    function automatic rec_t cur2();
        return {stim2, sig2, cnt2, ext_ready2, done2};
    endfunction

    task automatic cmp(input string nm, input rec_t act, input rec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got stim=%h sig=%h cnt=%0d rdy=%b done=%b, expected stim=%h sig=%h cnt=%0d rdy=%b done=%b",
                     nm, act.stim, act.sig, act.cnt, act.rdy, act.dn,
                     exp.stim, exp.sig, exp.cnt, exp.rdy, exp.dn);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    // Monitor for instance 1.
    always @(negedge clk) begin
        done1_q <= done1;
        if (!rst) begin
            if (busy1) begin
                if (bq1.size() == 0) flag("busy1 cycle with no expected record");
                else cmp("busy1", cur1(), bq1.pop_front());
            end
            if (done1 && !done1_q) begin
                if (dq1.size() == 0) flag("done1 rise with no expected record");
                else cmp("done1", cur1(), dq1.pop_front());
            end
        end
    end

    // Monitor for instance 2.
    always @(negedge clk) begin
        done2_q <= done2;
        if (!rst) begin
            if (busy2) begin
                if (bq2.size() == 0) flag("busy2 cycle with no expected record");
                else cmp("busy2", cur2(), bq2.pop_front());
            end
            if (done2 && !done2_q) begin
                if (dq2.size() == 0) flag("done2 rise with no expected record");
                else cmp("done2", cur2(), dq2.pop_front());
            end
        end
    end

    task automatic push_case1(input logic lp);
        bq1.push_back(mk(40'h0000000000, 32'h00000000, 16'd0, 1'b0, 1'b0));
        bq1.push_back(mk(40'h0000000001, 32'h00000000, 16'd1, 1'b0, 1'b0));
        bq1.push_back(mk(40'h0080200003, lp ? 32'h00000001 : 32'h00000000, 16'd2, 1'b0, 1'b0));
        dq1.push_back(mk(40'h0080200003, lp ? 32'h80200001 : 32'h00000000, 16'd2, 1'b0, 1'b1));
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 1) start1 = 1'b1;
        else            start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int limit);
        int n;
        n = 0;
        while (((which == 1) ? !done1 : !done2) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk_bit((which == 1) ? "done1 timeout" : "done2 timeout",
                (which == 1) ? done1 : done2, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mode = 1'b0;
        ext_valid = 1'b0; ext_vec = 32'h00000000; loop1 = 1'b1;
        repeat (2) @(negedge clk);
        cmp("reset1", cur1(), mk(40'h0, 32'h0, 16'd0, 1'b0, 1'b0));
        chk_bit("reset1 busy", busy1, 1'b0);
        cmp("reset2", cur2(), mk(40'h0, 32'h0, 16'd0, 1'b0, 1'b0));
        rst = 1'b0;

        // LFSR run with loopback, then frozen DONE state
        push_case1(1'b1);
        pulse(1);
        wait_done(1, 20);
        repeat (3) @(negedge clk);
        cmp("done1 frozen", cur1(), mk(40'h0080200003, 32'h80200001, 16'd2, 1'b0, 1'b1));
        chk_bit("done1 busy low", busy1, 1'b0);

        // Response tied to zero
        loop1 = 1'b0;
        push_case1(1'b0);
        pulse(1);
        wait_done(1, 20);
        @(negedge clk);
        loop1 = 1'b1;

        // External vectors with a three-clock stall before the first handshake
        mode = 1'b1;
        bq1.push_back(mk(40'h0, 32'h0, 16'd0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) bq1.push_back(mk(40'h0, 32'h0, 16'd0, 1'b1, 1'b0));
        bq1.push_back(mk(40'h00DEADBEEF, 32'h00000000, 16'd1, 1'b0, 1'b0));
        bq1.push_back(mk(40'h00DEADBEEF, 32'hDEADBEEF, 16'd1, 1'b1, 1'b0));
        bq1.push_back(mk(40'h0012345678, 32'hDEADBEEF, 16'd2, 1'b0, 1'b0));
        dq1.push_back(mk(40'h0012345678, 32'hABAE3611, 16'd2, 1'b0, 1'b1));
        pulse(1);
        mode = 1'b0;
        repeat (4) @(negedge clk);
        ext_vec = 32'hDEADBEEF; ext_valid = 1'b1;
        @(negedge clk);
        ext_vec = 32'h12345678;
        repeat (2) @(negedge clk);
        ext_valid = 1'b0;
        wait_done(1, 20);

        // Three-clock hold on the 40-bit instance
        for (int i = 0; i < 3; i++) bq2.push_back(mk(40'h0000000000, 32'h0, 16'd0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) bq2.push_back(mk(40'h0100000001, 32'h0, 16'd1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) bq2.push_back(mk(40'h0380200003, 32'h0, 16'd2, 1'b0, 1'b0));
        dq2.push_back(mk(40'h0380200003, 32'h80200000, 16'd2, 1'b0, 1'b1));
        pulse(2);
        wait_done(2, 40);

        // Reset mid-run at vec_cnt=1, then a clean rerun
        bq1.push_back(mk(40'h0000000000, 32'h0, 16'd0, 1'b0, 1'b0));
        bq1.push_back(mk(40'h0000000001, 32'h0, 16'd1, 1'b0, 1'b0));
        pulse(1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        cmp("rst abort1", cur1(), mk(40'h0, 32'h0, 16'd0, 1'b0, 1'b0));
        chk_bit("rst abort1 busy", busy1, 1'b0);
        chk_bit("rst abort2 done", done2, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        push_case1(1'b1);
        pulse(1);
        wait_done(1, 20);

        // start held during the run is ignored; start in DONE restarts
        push_case1(1'b1);
        @(negedge clk);
        start1 = 1'b1;
        repeat (2) @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 20);
        push_case1(1'b1);
        pulse(1);
        chk_bit("restart done drop", done1, 1'b0);
        wait_done(1, 20);

        @(negedge clk);
        chk_bit("bq1 drained", bq1.size() == 0, 1'b1);
        chk_bit("dq1 drained", dq1.size() == 0, 1'b1);
        chk_bit("bq2 drained", bq2.size() == 0, 1'b1);
        chk_bit("dq2 drained", dq2.size() == 0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
